// File: rtl/cpu_pkg.sv
// Shared definitions for the pipelined MIPS datapath.
// Register file geometry defaults and architectural register indices.
package cpu_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int ADDR_W_DEF   = 5;
    localparam int ZERO_REG_IDX = 0;
    localparam int REG_RA       = 31;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard for outstanding multi-cycle register writes.
// A mark sets a bit, a completing write clears it; set wins on collision.
module regfile_scoreboard
    import cpu_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_ok,
    input  logic [ADDR_W-1:0] waddr,
    input  logic              mark_valid,
    input  logic [ADDR_W-1:0] mark_addr,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic              busy1,
    output logic              busy2,
    output logic [ADDR_W:0]   busy_cnt
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZIDX = ADDR_W'(ZERO_REG_IDX);
    localparam logic HAS_ZERO = (ZERO_REG != 0);
    localparam logic HAS_BYP  = (BYPASS != 0);

    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] set_vec;
    logic [DEPTH-1:0] clr_vec;
    logic [DEPTH-1:0] busy_nxt;
    logic             set_ok;
    logic             inc;
    logic             dec;
    logic [ADDR_W:0]  cnt_nxt;

    assign set_ok = mark_valid && !rst && !(HAS_ZERO && mark_addr == ZIDX);

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (set_ok)
            set_vec[mark_addr] = 1'b1;
        if (wr_ok)
            clr_vec[waddr] = 1'b1;
        busy_nxt = (busy & ~clr_vec) | set_vec;
    end

    // A clear that collides with a set on the same bit is cancelled.
    assign inc = set_ok && !busy[mark_addr];
    assign dec = wr_ok && busy[waddr] && !(set_ok && mark_addr == waddr);
    assign cnt_nxt = busy_cnt + {{ADDR_W{1'b0}}, inc} - {{ADDR_W{1'b0}}, dec};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

    always_comb begin
        busy1 = busy[ra1];
        busy2 = busy[ra2];
        if ((HAS_ZERO && ra1 == ZIDX) || (HAS_BYP && wr_ok && waddr == ra1))
            busy1 = 1'b0;
        if ((HAS_ZERO && ra2 == ZIDX) || (HAS_BYP && wr_ok && waddr == ra2))
            busy2 = 1'b0;
    end

endmodule

// File: rtl/regfile_sb.sv
// Decode-stage register file with zero register, write-through bypass
// and a busy scoreboard for multi-cycle producers.
module regfile_sb
    import cpu_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic              mark_valid,
    input  logic [ADDR_W-1:0] mark_addr,
    output logic              busy1,
    output logic              busy2,
    output logic [ADDR_W:0]   busy_cnt
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZIDX = ADDR_W'(ZERO_REG_IDX);
    localparam logic HAS_ZERO = (ZERO_REG != 0);
    localparam logic HAS_BYP  = (BYPASS != 0);

    logic [DATA_W-1:0] regs [DEPTH];
    logic              wr_ok;

    // Gating with rst keeps the bypass path quiet while in reset.
    assign wr_ok = we && !rst && !(HAS_ZERO && waddr == ZIDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= '0;
        end else if (wr_ok) begin
            regs[waddr] <= wdata;
        end
    end

    always_comb begin
        rd1 = regs[ra1];
        rd2 = regs[ra2];
        if (HAS_ZERO && ra1 == ZIDX)
            rd1 = '0;
        else if (HAS_BYP && wr_ok && waddr == ra1)
            rd1 = wdata;
        if (HAS_ZERO && ra2 == ZIDX)
            rd2 = '0;
        else if (HAS_BYP && wr_ok && waddr == ra2)
            rd2 = wdata;
    end

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_sb (
        .clk        (clk),
        .rst        (rst),
        .wr_ok      (wr_ok),
        .waddr      (waddr),
        .mark_valid (mark_valid),
        .mark_addr  (mark_addr),
        .ra1        (ra1),
        .ra2        (ra2),
        .busy1      (busy1),
        .busy2      (busy2),
        .busy_cnt   (busy_cnt)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: default, no-bypass and no-zero-register
// instances share one stimulus stream.
module tb_regfile_sb;
    import cpu_pkg::*;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic        mark_valid;
    logic [4:0]  mark_addr;

    logic [31:0] rd1_d, rd2_d, rd1_n, rd2_n, rd1_z, rd2_z;
    logic        b1_d, b2_d, b1_n, b2_n, b1_z, b2_z;
    logic [5:0]  cnt_d, cnt_n, cnt_z;

    int errors = 0;
    int checks = 0;

    regfile_sb u_d (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .ra1(ra1), .ra2(ra2), .rd1(rd1_d), .rd2(rd2_d),
        .mark_valid(mark_valid), .mark_addr(mark_addr),
        .busy1(b1_d), .busy2(b2_d), .busy_cnt(cnt_d)
    );

    regfile_sb #(.BYPASS(0)) u_n (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .ra1(ra1), .ra2(ra2), .rd1(rd1_n), .rd2(rd2_n),
        .mark_valid(mark_valid), .mark_addr(mark_addr),
        .busy1(b1_n), .busy2(b2_n), .busy_cnt(cnt_n)
    );

    regfile_sb #(.ZERO_REG(0)) u_z (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .ra1(ra1), .ra2(ra2), .rd1(rd1_z), .rd2(rd2_z),
        .mark_valid(mark_valid), .mark_addr(mark_addr),
        .busy1(b1_z), .busy2(b2_z), .busy_cnt(cnt_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic        mv;
        logic [4:0]  ma;
        logic [31:0] e_rd1;
        logic [31:0] e_rd2;
        logic        e_b1;
        logic        e_b2;
        logic [5:0]  e_cnt;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0;
        mark_valid = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        we = 1'b0; waddr = '0; wdata = '0;
        ra1 = 5'd5; ra2 = 5'd0;
        mark_valid = 1'b0; mark_addr = '0;

        vecs[0]  = '{1'b1, 5'd3,  32'hA5A5, 5'd3,  5'd0,  1'b0, 5'd0,
                     32'hA5A5, 32'h0, 1'b0, 1'b0, 6'd0};
        vecs[1]  = '{1'b0, 5'd0,  32'h0,    5'd3,  5'd3,  1'b1, 5'd10,
                     32'hA5A5, 32'hA5A5, 1'b0, 1'b0, 6'd0};
        vecs[2]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0, 5'd10, 1'b1, 5'd0,
                     32'h0, 32'h0, 1'b0, 1'b1, 6'd1};
        vecs[3]  = '{1'b1, 5'd10, 32'h1234, 5'd10, 5'd0,  1'b1, 5'd12,
                     32'h1234, 32'h0, 1'b0, 1'b0, 6'd1};
        vecs[4]  = '{1'b0, 5'd0,  32'h0,    5'd12, 5'd10, 1'b0, 5'd0,
                     32'h0, 32'h1234, 1'b1, 1'b0, 6'd1};
        vecs[5]  = '{1'b1, 5'd12, 32'hCAFE, 5'd12, 5'd12, 1'b1, 5'd12,
                     32'hCAFE, 32'hCAFE, 1'b0, 1'b0, 6'd1};
        vecs[6]  = '{1'b0, 5'd0,  32'h0,    5'd12, 5'd3,  1'b0, 5'd0,
                     32'hCAFE, 32'hA5A5, 1'b1, 1'b0, 6'd1};
        vecs[7]  = '{1'b1, 5'd20, 32'h55,   5'd20, 5'd12, 1'b1, 5'd20,
                     32'h55, 32'hCAFE, 1'b0, 1'b1, 6'd1};
        vecs[8]  = '{1'b0, 5'd0,  32'h0,    5'd20, 5'd0,  1'b1, 5'd20,
                     32'h55, 32'h0, 1'b1, 1'b0, 6'd2};
        vecs[9]  = '{1'b1, 5'd20, 32'h66,   5'd12, 5'd20, 1'b1, 5'd5,
                     32'hCAFE, 32'h66, 1'b1, 1'b0, 6'd2};
        vecs[10] = '{1'b0, 5'd0,  32'h0,    5'd5,  5'd20, 1'b0, 5'd0,
                     32'h0, 32'h66, 1'b1, 1'b0, 6'd2};

        tick();
        check("rst_rd1", rd1_d, 32'h0);
        check("rst_cnt", {26'd0, cnt_d}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            we = vecs[i].we; waddr = vecs[i].waddr; wdata = vecs[i].wdata;
            ra1 = vecs[i].ra1; ra2 = vecs[i].ra2;
            mark_valid = vecs[i].mv; mark_addr = vecs[i].ma;
            #1;
            check($sformatf("v%0d_rd1", i), rd1_d, vecs[i].e_rd1);
            check($sformatf("v%0d_rd2", i), rd2_d, vecs[i].e_rd2);
            check($sformatf("v%0d_b1", i), {31'd0, b1_d}, {31'd0, vecs[i].e_b1});
            check($sformatf("v%0d_b2", i), {31'd0, b2_d}, {31'd0, vecs[i].e_b2});
            check($sformatf("v%0d_cnt", i), {26'd0, cnt_d}, {26'd0, vecs[i].e_cnt});
            tick();
        end
        idle();

        // Asynchronous reset between edges with outstanding marks.
        we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; ra1 = 5'd5;
        tick();
        idle();
        #1;
        check("pre_rst_rd1", rd1_d, 32'hDEADBEEF);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_rd1", rd1_d, 32'h0);
        check("async_rst_cnt", {26'd0, cnt_d}, 32'd0);
        we = 1'b1; waddr = 5'd6; wdata = 32'h1; ra1 = 5'd6;
        mark_valid = 1'b1; mark_addr = 5'd6;
        #1;
        check("rst_bypass_rd1", rd1_d, 32'h0);
        tick();
        idle();
        rst = 1'b0;
        tick();
        check("rst_wr_ignored", rd1_d, 32'h0);
        check("rst_mark_ignored", {26'd0, cnt_d}, 32'd0);

        // Zero register on both flavours.
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; ra1 = 5'd0;
        mark_valid = 1'b1; mark_addr = 5'd0;
        tick();
        idle();
        #1;
        check("zero_rd1", rd1_d, 32'h0);
        check("zero_b1", {31'd0, b1_d}, 32'd0);
        check("zero_cnt", {26'd0, cnt_d}, 32'd0);
        check("nozero_rd1", rd1_z, 32'hFFFFFFFF);
        check("nozero_b1", {31'd0, b1_z}, 32'd1);
        do_reset();

        // Bypass versus no-bypass.
        we = 1'b1; waddr = 5'd7; wdata = 32'h11;
        tick();
        wdata = 32'h22; ra1 = 5'd7; ra2 = 5'd7;
        #1;
        check("byp_rd1", rd1_d, 32'h22);
        check("byp_rd2", rd2_d, 32'h22);
        check("nobyp_rd1", rd1_n, 32'h11);
        check("nobyp_rd2", rd2_n, 32'h11);
        tick();
        idle();
        #1;
        check("byp_after", rd1_d, 32'h22);
        check("nobyp_after", rd2_n, 32'h22);

        // Scoreboard lifecycle.
        mark_valid = 1'b1; mark_addr = 5'd9; ra1 = 5'd9;
        tick();
        idle();
        #1;
        check("life_b1", {31'd0, b1_d}, 32'd1);
        check("life_cnt", {26'd0, cnt_d}, 32'd1);
        repeat (3) tick();
        we = 1'b1; waddr = 5'd9; wdata = 32'h5A;
        #1;
        check("life_wr_b1", {31'd0, b1_d}, 32'd0);
        check("life_wr_b1_nobyp", {31'd0, b1_n}, 32'd1);
        tick();
        idle();
        #1;
        check("life_done_b1", {31'd0, b1_d}, 32'd0);
        check("life_done_cnt", {26'd0, cnt_d}, 32'd0);
        check("life_done_rd1", rd1_d, 32'h5A);

        // Collision on a busy register.
        mark_valid = 1'b1; mark_addr = 5'd4;
        tick();
        we = 1'b1; waddr = 5'd4; wdata = 32'h77;
        tick();
        idle();
        ra1 = 5'd4;
        #1;
        check("coll_rd1", rd1_d, 32'h77);
        check("coll_b1", {31'd0, b1_d}, 32'd1);
        check("coll_cnt", {26'd0, cnt_d}, 32'd1);
        do_reset();

        // Fill the scoreboard.
        for (int i = 0; i < 32; i++) begin
            mark_valid = 1'b1; mark_addr = 5'(i);
            tick();
        end
        idle();
        #1;
        check("fill_cnt_z", {26'd0, cnt_z}, 32'd32);
        check("fill_cnt_d", {26'd0, cnt_d}, 32'd31);
        mark_valid = 1'b1; mark_addr = 5'd0;
        tick();
        idle();
        #1;
        check("fill_nowrap", {26'd0, cnt_z}, 32'd32);
        we = 1'b1; waddr = 5'(REG_RA); wdata = 32'h31;
        tick();
        idle();
        #1;
        check("fill_wr_z", {26'd0, cnt_z}, 32'd31);
        check("fill_wr_d", {26'd0, cnt_d}, 32'd30);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised successor to the single-cycle register file for the pipelined MIPS datapath. It provides a configurable-width and configurable-depth register array with asynchronous clear, hard-wired zero register, write-to-read bypass, and a per-register busy scoreboard. The scoreboard tracks outstanding multi-cycle writes, such as loads, so the hazard unit can stall dependent instructions. The block sits in the decode stage; writeback drives the write port and issue drives the mark port.

Parameters:
DATA_W, 32, data width of each register
ADDR_W, 5, address width; depth = 2**ADDR_W
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and is never busy
BYPASS, 1, 1 = same-cycle write data forwarded to read ports

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
we  input  1  write enable (writeback)
waddr  input  ADDR_W  write address
wdata  input  DATA_W  write data
ra1  input  ADDR_W  read address, port 1
ra2  input  ADDR_W  read address, port 2
rd1  output  DATA_W  read data, port 1
rd2  output  DATA_W  read data, port 2
mark_valid  input  1  issue of a multi-cycle producer; set busy on mark_addr
mark_addr  input  ADDR_W  destination register of the issued producer
busy1  output  1  ra1 has an outstanding write
busy2  output  1  ra2 has an outstanding write
busy_cnt  output  ADDR_W+1  number of registers currently busy

Behaviour:
- Reset: while rst=1, asynchronously clear every register to 0, all busy bits to 0, and busy_cnt to 0.
  - rd1/rd2 read 0 and busy1/busy2 read 0 during reset.
  - Writes and marks are ignored while rst=1.
  - A reset mid-operation discards outstanding marks.
- Write: at posedge clk, if we=1, regs[waddr] <= wdata.
  - Dropped when ZERO_REG=1 and waddr=0.
  - Writing a non-busy register is legal; it is a plain write.
- Read: combinational, zero latency. rdN = regs[raN].
  - If ZERO_REG=1 and raN=0, rdN = 0.
  - If BYPASS=1, we=1, waddr=raN and the write is not dropped, then rdN = wdata. This is write-through in the same cycle.
  - Both ports may read the same address.
- Scoreboard: one busy bit per register, updated at posedge clk.
  - Set when mark_valid=1, unless ZERO_REG=1 and mark_addr=0.
  - Cleared when a non-dropped write hits that address.
  - Simultaneous mark and write to the same address: set wins, because a new producer was issued after the completing one. Data is still written.
  - Simultaneous mark and write to different addresses: both take effect.
  - Marking an already-busy register leaves it busy; there is no nesting count.
- busyN = busy[raN], forced 0 when:
  - raN is the zero register (ZERO_REG=1), or
  - BYPASS=1 and a same-cycle write to raN is present, since the data is already forwarded.
- busy_cnt: registered, updated in the same edge as the busy bits.
  - +1 on a set of a non-busy bit; -1 on a clear of a busy bit.
  - Net 0 for a set-wins collision on an already-busy bit.
  - Range 0..2**ADDR_W; never wraps.

Decomposition:
- Shared package cpu_pkg holds:
  - DATA_W and ADDR_W defaults
  - ZERO_REG_IDX = 0
  - REG_RA = 31 (link register, used by benches)
- Natural sub-module: regfile_scoreboard, containing the busy-bit vector, set/clear priority, busy_cnt counter and busy lookups.
- regfile_sb instantiates it alongside the register array and bypass muxes.

Test Plan:
- Reset clear: write 32'hDEADBEEF to r5, assert rst asynchronously between edges -> rd1 (ra1=5) = 0 immediately, busy_cnt = 0.
- Zero register: we=1, waddr=0, wdata=32'hFFFFFFFF; mark_valid=1, mark_addr=0 -> rd1 (ra1=0) = 0, busy1 = 0, busy_cnt stays 0.
- Bypass: r7 = 32'h11; same cycle we=1, waddr=7, wdata=32'h22, ra1=ra2=7 -> rd1 = rd2 = 32'h22 before the edge, 32'h22 after. With BYPASS=0 -> 32'h11 before the edge.
- Scoreboard lifecycle: mark r9 -> busy1 (ra1=9) = 1 next cycle, busy_cnt = 1. Three cycles later write r9 = 32'h5A -> during that write cycle busy1 = 0 via bypass; after the edge busy1 = 0, busy_cnt = 0.
- Collision: r4 busy; same edge we=1, waddr=4, wdata=32'h77 and mark_valid=1, mark_addr=4 -> regs[4] = 32'h77, busy[4] stays 1, busy_cnt unchanged.
- Fill: mark all 32 registers with ZERO_REG=0 -> busy_cnt = 32 and does not wrap. Write r31 -> busy_cnt = 31.
